// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory (dm_4k) between the CPU
// data port (port 0) and a debug/DMA port (port 1). Arbitration is
// combinational; read data is registered per port. Port 1 may lock the
// memory for a burst, bounded by MAX_BURST while port 0 is waiting.
module dm_arbiter #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [3:0]    wbe0,
  input  logic [3:0]    wbe1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          cpu_stall,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  output logic [3:0]    dm_wbyte_enable,
  input  logic [DW-1:0] dm_dout
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mode_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  mode_t      mode, mode_nxt;
  logic       last, last_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic [3:0] sel_wbe;
  logic       sel_we;

  // Arbitration state register; reset leaves port 0 winning first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode      <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      mode      <= mode_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Grant decision and next arbitration state.
  // A LOCKED cycle whose lock condition has dropped falls through to the
  // IDLE rules in the same cycle, so both cases share the else-branch.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    mode_nxt      = mode;
    last_nxt      = last;
    burst_cnt_nxt = burst_cnt;
    if (rst) begin
      if (mode == LOCKED && req1 && lock1) begin
        if (req0 && burst_cnt == MAX_CNT) begin
          // burst exhausted while the CPU waits: hand one cycle to port 0
          gnt0          = 1'b1;
          mode_nxt      = IDLE;
          last_nxt      = 1'b0;
          burst_cnt_nxt = '0;
        end else begin
          gnt1 = 1'b1;
          if (req0 && burst_cnt < MAX_CNT)
            burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end else begin
        mode_nxt = IDLE;
        if (req0 && req1) begin
          gnt0     = last;
          gnt1     = ~last;
          last_nxt = ~last;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        if (gnt1 && lock1) begin
          mode_nxt      = LOCKED;
          burst_cnt_nxt = 8'd1;
        end
      end
    end
  end

  // Memory-side mux: port 1 only when it holds the grant, port 0 otherwise.
  always_comb begin
    sel_we          = gnt1 ? we1 : we0;
    sel_wbe         = gnt1 ? wbe1 : wbe0;
    dm_addr         = gnt1 ? addr1 : addr0;
    dm_din          = gnt1 ? wdata1 : wdata0;
    dm_we           = (gnt0 | gnt1) & sel_we;
    dm_wbyte_enable = dm_we ? sel_wbe : '0;
    cpu_stall       = req0 & ~gnt0;
  end

  // Registered read return for port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0  <= '0;
      rvalid0 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      if (gnt0 && !we0)
        rdata0 <= dm_dout;
    end
  end

  // Registered read return for port 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1  <= '0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= gnt1 & ~we1;
      if (gnt1 && !we1)
        rdata1 <= dm_dout;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural dm_4k model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wbe0, wbe1;
  logic        gnt0, gnt1, rvalid0, rvalid1, cpu_stall, dm_we;
  logic [31:0] rdata0, rdata1, dm_din, dm_dout;
  logic [9:0]  dm_addr;
  logic [3:0]  dm_wbyte_enable;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;

  dm_arbiter #(.AW(10), .DW(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wbe0(wbe0), .wbe1(wbe1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .cpu_stall(cpu_stall),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_wbyte_enable(dm_wbyte_enable), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // dm_4k model: combinational read, byte-enabled write; preloaded on first edge.
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i >= 16 && i < 28) ? (32'hA000_0000 + 32'(i)) : 32'h0;
      mem_init <= 1'b1;
    end else if (dm_we) begin
      for (int b = 0; b < 4; b++)
        if (dm_wbyte_enable[b]) mem[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wbe0 = '0; wbe1 = '0;
  endtask

  task automatic idle();
    clear_inputs();
    cycle();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    cycle();
    cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    req0 = 1; req1 = 1;
    #2;
    checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", cpu_stall); end
    checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    cycle();
    cycle();
    clear_inputs();
    rst = 1;
    cycle();
  endtask

  task automatic test_single_port0();
    idle();
    req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 32'hDEADBEEF; wbe0 = 4'hF;
    #1;
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL p0_wr_gnt got=%b exp=1", gnt0); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL p0_wr_stall got=%b exp=0", cpu_stall); end
    checks++; if (dm_we !== 1'b1 || dm_wbyte_enable !== 4'hF || dm_addr !== 10'h005) begin
      failures++; $display("FAIL p0_wr_mux got=we%b be%h a%h exp=we1 beF a005", dm_we, dm_wbyte_enable, dm_addr); end
    cycle();
    we0 = 0;
    #1;
    checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL p0_rd_gnt got=%b exp=1", gnt0); end
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL p0_wr_no_rvalid got=%b exp=0", rvalid0); end
    cycle();
    req0 = 0;
    #1;
    checks++; if (rvalid0 !== 1'b1) begin failures++; $display("FAIL p0_rvalid got=%b exp=1", rvalid0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL p0_rdata got=%h exp=deadbeef", rdata0); end
    cycle();
    checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL p0_rvalid_pulse got=%b exp=0", rvalid0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL p0_rdata_hold got=%h exp=deadbeef", rdata0); end
  endtask

  task automatic test_contention();
    logic exp0;
    do_reset();
    req0 = 1; req1 = 1; lock1 = 0; addr0 = 10'h040; addr1 = 10'h041;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp0 = (c % 2 == 0);
      checks++; if (gnt0 !== exp0 || gnt1 !== ~exp0) begin
        failures++; $display("FAIL contend_gnt c=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, exp0, ~exp0); end
      checks++; if (cpu_stall !== ~exp0) begin
        failures++; $display("FAIL contend_stall c=%0d got=%b exp=%b", c, cpu_stall, ~exp0); end
      cycle();
    end
    idle();
  endtask

  task automatic test_burst_preempt();
    int   n;
    logic p0done, exp1, prev1;
    idle();
    n = 0; p0done = 0; prev1 = 0;
    req1 = 1; lock1 = 1; we1 = 0;
    we0 = 1; addr0 = 10'h200; wdata0 = 32'h5555AAAA; wbe0 = 4'hF;
    for (int c = 0; c < 13; c++) begin
      addr1 = 10'(16 + n);
      req0  = (c >= 1) && !p0done;
      #1;
      exp1 = (c != 8);
      checks++; if (gnt1 !== exp1 || gnt0 !== ~exp1) begin
        failures++; $display("FAIL burst_gnt c=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, ~exp1, exp1); end
      checks++; if (cpu_stall !== (req0 & exp1)) begin
        failures++; $display("FAIL burst_stall c=%0d got=%b exp=%b", c, cpu_stall, req0 & exp1); end
      checks++; if (rvalid1 !== prev1) begin
        failures++; $display("FAIL burst_rvalid1 c=%0d got=%b exp=%b", c, rvalid1, prev1); end
      if (prev1) begin
        checks++; if (rdata1 !== 32'hA000_0000 + 32'(16 + n - 1)) begin
          failures++; $display("FAIL burst_rdata1 c=%0d got=%h exp=%h", c, rdata1, 32'hA000_0000 + 32'(16 + n - 1)); end
      end
      if (c == 8) p0done = 1;
      prev1 = exp1;
      if (exp1) n++;
      cycle();
    end
    clear_inputs();
    #1;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hA000_001B) begin
      failures++; $display("FAIL burst_last got=%b/%h exp=1/a000001b", rvalid1, rdata1); end
    cycle();
  endtask

  task automatic test_lock_no_contention();
    idle();
    req1 = 1; lock1 = 1; we1 = 1; wbe1 = 4'hF;
    for (int i = 0; i < 12; i++) begin
      addr1 = 10'(32 + i); wdata1 = 32'hC0DE_0000 + 32'(i);
      #1;
      checks++; if (gnt1 !== 1'b1 || rvalid1 !== 1'b0) begin
        failures++; $display("FAIL lock_gnt i=%0d got=gnt%b rv%b exp=gnt1 rv0", i, gnt1, rvalid1); end
      cycle();
    end
    checks++; if (dut.burst_cnt !== 8'd1) begin failures++; $display("FAIL lock_cnt got=%0d exp=1", dut.burst_cnt); end
    clear_inputs();
    req0 = 1; addr0 = 10'h02B;
    cycle();
    req0 = 0;
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hC0DE000B) begin
      failures++; $display("FAIL lock_readback got=%b/%h exp=1/c0de000b", rvalid0, rdata0); end
    cycle();
  endtask

  task automatic test_byte_enable();
    idle();
    req1 = 1; we1 = 1; addr1 = 10'h100; wdata1 = 32'h11223344; wbe1 = 4'b0010;
    #1;
    checks++; if (dm_we !== 1'b1 || dm_wbyte_enable !== 4'b0010) begin
      failures++; $display("FAIL be_write got=we%b be%b exp=we1 be0010", dm_we, dm_wbyte_enable); end
    cycle();
    we1 = 0;
    #1;
    checks++; if (dm_we !== 1'b0 || dm_wbyte_enable !== 4'b0000) begin
      failures++; $display("FAIL be_read_gate got=we%b be%b exp=we0 be0000", dm_we, dm_wbyte_enable); end
    cycle();
    clear_inputs();
    #1;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h00003300) begin
      failures++; $display("FAIL be_readback got=%b/%h exp=1/00003300", rvalid1, rdata1); end
    cycle();
  endtask

  task automatic test_async_reset();
    idle();
    req1 = 1; lock1 = 1; we1 = 0;
    for (int c = 0; c < 3; c++) begin
      addr1 = 10'(16 + c);
      #1;
      checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL rstb_gnt c=%0d got=%b exp=1", c, gnt1); end
      cycle();
    end
    addr1 = 10'h013;
    #1;
    rst = 0; req0 = 1;
    #1;
    checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin
      failures++; $display("FAIL rstb_gnt_async got=%b%b exp=00", gnt0, gnt1); end
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin
      failures++; $display("FAIL rstb_rvalid_async got=%b/%h exp=0/0", rvalid1, rdata1); end
    checks++; if (cpu_stall !== 1'b1 || dm_we !== 1'b0) begin
      failures++; $display("FAIL rstb_stall got=st%b we%b exp=st1 we0", cpu_stall, dm_we); end
    checks++; if (dut.burst_cnt !== 8'd0) begin failures++; $display("FAIL rstb_cnt got=%0d exp=0", dut.burst_cnt); end
    cycle();
    cycle();
    rst = 1; req0 = 1; req1 = 1; lock1 = 0; addr0 = 10'h005;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL rstb_first got=%b%b exp=10", gnt0, gnt1); end
    cycle();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      failures++; $display("FAIL rstb_second got=%b%b exp=01", gnt0, gnt1); end
    idle();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_single_port0();
    test_contention();
    test_burst_preempt();
    test_lock_no_contention();
    test_byte_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
